// File: rtl/cache_pkg.sv
// Shared state encoding, default cache geometry and address-field width helpers
// for set_assoc_cache and its metadata sub-module.
package cache_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_WAYS       = 2;
    localparam int DEF_SETS       = 64;
    localparam int DEF_WORDS      = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        WRITE_MEM
    } state_e;

    function automatic int off_w(input int words);
        return $clog2(words * 2);
    endfunction

    function automatic int set_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int aw, input int sets, input int words);
        return aw - off_w(words) - set_w(sets);
    endfunction

    // A direct-mapped cache still needs a 1-bit way/age field to keep widths legal.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_way_meta.sv
// Per-set tag, valid and age storage for set_assoc_cache: hit detection,
// victim selection (lowest invalid way, else oldest) and age-based LRU update.
module cache_way_meta
    import cache_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int SETS  = DEF_SETS,
    parameter int TAG_W = tag_w(DEF_ADDR_WIDTH, DEF_SETS, DEF_WORDS),
    parameter int SET_W = set_w(SETS),
    parameter int WAY_W = way_w(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] set_idx,
    input  logic [TAG_W-1:0] tag_in,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim,
    input  logic             touch,
    input  logic             inval,
    input  logic             validate,
    input  logic [WAY_W-1:0] op_way
);

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];

    logic [WAYS-1:0]  valid_row_d;
    logic [WAY_W-1:0] age_row_d [WAYS];
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] max_age;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        max_age   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        // Ages form a permutation of 0..WAYS-1, so the maximum is unique.
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[set_idx][w] >= max_age) begin
                max_age = age_q[set_idx][w];
                lru_way = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : lru_way;
    end

    always_comb begin
        valid_row_d = valid_q[set_idx];
        for (int w = 0; w < WAYS; w++) begin
            age_row_d[w] = age_q[set_idx][w];
        end
        if (inval) begin
            valid_row_d[op_way] = 1'b0;
        end
        if (validate) begin
            valid_row_d[op_way] = 1'b1;
        end
        if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == op_way) begin
                    age_row_d[w] = '0;
                end else if (age_q[set_idx][w] < age_q[set_idx][op_way]) begin
                    age_row_d[w] = age_q[set_idx][w] + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            valid_q[set_idx] <= valid_row_d;
            for (int w = 0; w < WAYS; w++) begin
                age_q[set_idx][w] <= age_row_d[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (validate) begin
            tag_q[set_idx][op_way] <= tag_in;
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-through, no-write-allocate set-associative cache with block fill from memory.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int WORDS      = DEF_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  cpu_busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
`ifdef CACHE_STATS_EN
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int OFF_W = off_w(WORDS);
    localparam int SET_W = set_w(SETS);
    localparam int TAG_W = tag_w(ADDR_WIDTH, SETS, WORDS);
    localparam int WAY_W = way_w(WAYS);
    localparam int WRD_W = $clog2(WORDS);
    localparam int IDX_W = SET_W + WAY_W + WRD_W;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WRD_W-1:0]      word_cnt_q, word_cnt_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic                  refill_q, refill_d;
`ifdef CACHE_STATS_EN
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;
`endif

    logic [DATA_WIDTH-1:0] data_q [2**IDX_W];
    logic                  data_we;
    logic [IDX_W-1:0]      data_idx;
    logic [DATA_WIDTH-1:0] data_wval;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [SET_W-1:0]      set_idx;
    logic [TAG_W-1:0]      tag;
    logic [WRD_W-1:0]      word_idx;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim_w;
    logic                  touch;
    logic                  inval;
    logic                  validate;
    logic [WAY_W-1:0]      op_way;

    assign set_idx  = addr_q[OFF_W +: SET_W];
    assign tag      = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign word_idx = addr_q[1 +: WRD_W];
    assign rd_word  = data_q[{set_idx, hit_way, word_idx}];

    cache_way_meta #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_meta (
        .clk      (clk),
        .rst      (rst),
        .set_idx  (set_idx),
        .tag_in   (tag),
        .hit      (hit),
        .hit_way  (hit_way),
        .victim   (victim_w),
        .touch    (touch),
        .inval    (inval),
        .validate (validate),
        .op_way   (op_way)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        word_cnt_d  = word_cnt_q;
        victim_d    = victim_q;
        refill_d    = refill_q;
`ifdef CACHE_STATS_EN
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
`endif
        touch       = 1'b0;
        inval       = 1'b0;
        validate    = 1'b0;
        op_way      = hit_way;
        data_we     = 1'b0;
        data_idx    = {set_idx, hit_way, word_idx};
        data_wval   = wdata_q;

        case (state_q)
            IDLE: begin
                // The cycle carrying cpu_done still reports busy; release it here.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (cpu_req) begin
                    addr_d   = cpu_addr;
                    wr_d     = cpu_wr;
                    wdata_d  = cpu_wdata;
                    busy_d   = 1'b1;
                    refill_d = 1'b0;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                refill_d = 1'b0;
`ifdef CACHE_STATS_EN
                if (!refill_q) begin
                    if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                    if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                end
`endif
                if (hit) begin
                    touch = 1'b1;
                    if (wr_q) begin
                        data_we = 1'b1;
                    end else begin
                        rdata_d = rd_word;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (wr_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = WRITE_MEM;
                end else if (!hit) begin
                    op_way     = victim_w;
                    inval      = 1'b1;
                    victim_d   = victim_w;
                    word_cnt_d = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    state_d    = FILL;
                end
            end
            FILL: begin
                op_way = victim_q;
                if (mem_req_q && mem_ack) begin
                    data_we   = 1'b1;
                    data_idx  = {set_idx, victim_q, word_cnt_q};
                    data_wval = mem_rdata;
                    if (word_cnt_q == WRD_W'(WORDS - 1)) begin
                        mem_req_d = 1'b0;
                        validate  = 1'b1;
                        refill_d  = 1'b1;
                        state_d   = LOOKUP;
                    end else begin
                        word_cnt_d = word_cnt_q + WRD_W'(1);
                        mem_addr_d = mem_addr_q + ADDR_WIDTH'(2);
                    end
                end
            end
            WRITE_MEM: begin
                if (mem_req_q && mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            word_cnt_q  <= '0;
            victim_q    <= '0;
            refill_q    <= 1'b0;
`ifdef CACHE_STATS_EN
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            word_cnt_q  <= word_cnt_d;
            victim_q    <= victim_d;
            refill_q    <= refill_d;
`ifdef CACHE_STATS_EN
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[data_idx] <= data_wval;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_done  = done_q;
    assign cpu_busy  = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef CACHE_STATS_EN
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: memory model returns data = address on fills.
`timescale 1ns/1ps
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    set_assoc_cache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_busy  (cpu_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
`ifdef CACHE_STATS_EN
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
`endif
        .mem_rdata (mem_rdata)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          rd_txn = 0;
    int          wr_txn = 0;
    int          req_cyc = 0;
    logic [15:0] rd_log[$];
    logic [15:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;

    // Memory: acknowledge every other cycle while a request is held.
    always @(negedge clk) begin
        if (mem_req && !mem_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr;
        end else begin
            mem_ack   = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (mem_req) begin
            req_cyc++;
            if (mem_ack) begin
                if (mem_we) begin
                    wr_txn++;
                    last_waddr = mem_addr;
                    last_wdata = mem_wdata;
                end else begin
                    rd_txn++;
                    rd_log.push_back(mem_addr);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output int cyc);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("busy_set", cpu_busy, 1);
        while (!cpu_done && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("done_seen", cpu_done, 1);
        rd = cpu_rdata;
        @(posedge clk);
        @(negedge clk);
        chk("busy_clear", cpu_busy, 0);
    endtask

    logic [15:0] rd;
    int          cyc;
    int          r0, w0, q0, guard;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", cpu_done, 0);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;

        // Cold read fills the whole block in word order.
        r0 = rd_txn;
        rd_log.delete();
        access(1'b0, 16'h1234, 16'h0, rd, cyc);
        chk("cold_rdata", rd, 16'h1234);
        chk("cold_reads", rd_txn - r0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("cold_addr", (i < rd_log.size()) ? rd_log[i] : 16'hFFFF, 16'h1230 + 16'(2 * i));
        end

        q0 = req_cyc;
        access(1'b0, 16'h1236, 16'h0, rd, cyc);
        chk("hit_latency", cyc, 2);
        chk("hit_rdata", rd, 16'h1236);
        chk("hit_no_mem", req_cyc - q0, 0);

        // LRU in set 0.
        r0 = rd_txn;
        access(1'b0, 16'h0400, 16'h0, rd, cyc);
        chk("lru_fill_a", rd_txn - r0, 8);
        r0 = rd_txn;
        access(1'b0, 16'h0800, 16'h0, rd, cyc);
        chk("lru_fill_b", rd_txn - r0, 8);
        chk("lru_rdata_b", rd, 16'h0800);
        q0 = req_cyc;
        access(1'b0, 16'h0400, 16'h0, rd, cyc);
        chk("lru_touch_a", req_cyc - q0, 0);
        chk("lru_touch_rdata", rd, 16'h0400);
        r0 = rd_txn;
        access(1'b0, 16'h0C00, 16'h0, rd, cyc);
        chk("lru_fill_c", rd_txn - r0, 8);
        chk("lru_rdata_c", rd, 16'h0C00);
        q0 = req_cyc;
        access(1'b0, 16'h0400, 16'h0, rd, cyc);
        chk("lru_a_kept", req_cyc - q0, 0);
        chk("lru_a_rdata", rd, 16'h0400);
        r0 = rd_txn;
        access(1'b0, 16'h0800, 16'h0, rd, cyc);
        chk("lru_b_evicted", rd_txn - r0, 8);
        chk("lru_b_rdata", rd, 16'h0800);

        // Write hit: write-through plus cached update.
        r0 = rd_txn;
        w0 = wr_txn;
        access(1'b1, 16'h1234, 16'hBEEF, rd, cyc);
        chk("wh_writes", wr_txn - w0, 1);
        chk("wh_reads", rd_txn - r0, 0);
        chk("wh_addr", last_waddr, 16'h1234);
        chk("wh_data", last_wdata, 16'hBEEF);
        q0 = req_cyc;
        access(1'b0, 16'h1234, 16'h0, rd, cyc);
        chk("wh_read_back", rd, 16'hBEEF);
        chk("wh_read_no_mem", req_cyc - q0, 0);

        // Write miss: no allocate.
        r0 = rd_txn;
        w0 = wr_txn;
        access(1'b1, 16'h2000, 16'h5555, rd, cyc);
        chk("wm_writes", wr_txn - w0, 1);
        chk("wm_reads", rd_txn - r0, 0);
        chk("wm_addr", last_waddr, 16'h2000);
        chk("wm_data", last_wdata, 16'h5555);
        r0 = rd_txn;
        access(1'b0, 16'h2000, 16'h0, rd, cyc);
        chk("wm_read_miss", rd_txn - r0, 8);
        chk("wm_read_rdata", rd, 16'h2000);

        // Reset in the middle of a fill.
        r0 = rd_txn;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h3000;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        guard = 0;
        while ((rd_txn - r0) < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_acks", rd_txn - r0, 3);
        rst = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_busy", cpu_busy, 0);
        @(negedge clk);
        rst = 1'b1;
        r0 = rd_txn;
        rd_log.delete();
        access(1'b0, 16'h3000, 16'h0, rd, cyc);
        chk("refill_reads", rd_txn - r0, 8);
        chk("refill_first", (rd_log.size() > 0) ? rd_log[0] : 16'hFFFF, 16'h3000);
        chk("refill_rdata", rd, 16'h3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: word width, fixed at 16 bits (2 bytes per word).
REQ-003 SHALL have parameter WAYS, default 2: associativity, power of 2, 1..8.
REQ-004 SHALL have parameter SETS, default 64: set count, power of 2.
REQ-005 SHALL have parameter WORDS, default 8: words per block, power of 2.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have ports cpu_req (in, 1), cpu_wr (in, 1), cpu_addr (in, ADDR_WIDTH) and cpu_wdata (in, 16): CPU access request.
REQ-009 SHALL have ports cpu_rdata (out, 16), cpu_done (out, 1; one-cycle pulse) and cpu_busy (out, 1): CPU response.
REQ-010 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, ADDR_WIDTH), mem_wdata (out, 16), mem_ack (in, 1) and mem_rdata (in, 16): backing memory.

Function
REQ-011 SHALL split the address as follows: offset = low log2(WORDS*2) bits, word index = offset[msb:1], set = next log2(SETS) bits, tag = remaining bits.
REQ-012 SHALL implement an FSM with states IDLE, LOOKUP, FILL, WRITE_MEM.
REQ-013 SHALL, in IDLE with cpu_req=1, latch addr/wr/wdata, assert cpu_busy, and go to LOOKUP; cpu_busy SHALL stay 1 until the cycle after cpu_done.
REQ-014 SHALL, in LOOKUP, declare a hit on a way when valid=1 and the stored tag equals the latched tag; at most one way SHALL match.
REQ-015 SHALL, on a read hit, drive the word onto cpu_rdata, pulse cpu_done in the LOOKUP cycle, update LRU, and return to IDLE; read-hit latency is 2 cycles from request.
REQ-016 SHALL, on a read miss, pick a victim (the lowest invalid way, else the LRU way), clear its valid bit, and go to FILL.
REQ-017 SHALL, in FILL, fetch words 0..WORDS-1 of the block in order with mem_we=0, mem_req held with a stable mem_addr until mem_ack, one word per ack.
REQ-018 SHALL write mem_rdata into the victim on each ack; after the last ack it SHALL set tag, set valid, and return to LOOKUP, where the access hits.
REQ-019 SHALL treat writes as write-through with no write-allocate; on a write hit it SHALL update the cached word and LRU in LOOKUP.
REQ-020 SHALL handle every write (hit or miss) in WRITE_MEM: mem_req=1, mem_we=1, mem_wdata = cpu_wdata; on mem_ack it SHALL pulse cpu_done and go to IDLE.
REQ-021 SHALL keep an age counter of log2(WAYS) bits per way: an accessed way goes to 0, and younger ways increment; LRU = the way with maximum age.
REQ-022 SHALL ignore cpu_req while cpu_busy=1, and SHALL ignore mem_ack while mem_req=0.
REQ-023 SHALL leave cpu_rdata unchanged except on a read hit.

Reset
REQ-024 SHALL, while rst=0, immediately force: FSM to IDLE, all valid bits 0, way w age = w, and cpu_done, cpu_busy, mem_req, mem_we, cpu_rdata, mem_addr, mem_wdata all 0.
REQ-025 SHALL abort any FILL in progress on reset, leaving no partially filled line valid.
REQ-026 SHALL NOT reset data and tag storage.

Configuration
REQ-027 SHALL, with CACHE_STATS_EN defined, add outputs hit_cnt and miss_cnt (16 bits each, saturating); each LOOKUP entry SHALL count exactly once, and the post-FILL re-lookup SHALL NOT count.
REQ-028 SHALL, without CACHE_STATS_EN, have neither the ports nor the counters; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL put in package cache_pkg: the state enum, the address-field width functions, and the default parameter constants.
REQ-030 SHALL place tag, valid and age storage plus victim selection in sub-module cache_way_meta, with data storage as a register array in the top level.

Verification
REQ-031 SHALL verify cold read: read 0x1234 with memory returning word = addr -> 8 mem_reqs at 0x1230..0x123E, then cpu_done with cpu_rdata=0x1234.
REQ-032 SHALL verify read hit: re-read 0x1236 -> cpu_done 2 cycles after cpu_req, cpu_rdata=0x1236, no mem_req.
REQ-033 SHALL verify LRU eviction: fill 0x0400 and 0x0800 (set 0), touch 0x0400, read 0x0C00 -> evicts the 0x0800 way; then reading 0x0800 misses and reading 0x0400 hits.
REQ-034 SHALL verify write hit: write 0xBEEF to 0x1234 -> mem_we at 0x1234, cpu_done after ack; a following read of 0x1234 returns 0xBEEF with no mem_req.
REQ-035 SHALL verify write miss: write 0x5555 to 0x2000 -> exactly one mem write; a following read of 0x2000 misses.
REQ-036 SHALL verify reset mid-FILL: assert rst=0 after 3 acks, then re-read the same address -> full 8-word fill again.
